wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single register-file write port among
//  three result producers: src0 ALU, src1 load unit, src2 PC+4/link.
//  Drives the 2-bit select for the 3:1 result mux (00=d0, 01=d1, 1x=d2).
//  Registers the winning rd/data into a one-entry writeback stage feeding rf we3/a3/wd3.
//  Sits between the execute/memory units and the register file.
// PARAMETERS
//  WIDTH   32  data width of each result source and of rf_wd
//  REGW    5   register index width (rd, rf_rd)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   3       per-source write request; bit i = src i
//  req_rd     in   3*REGW  destination register, src i at [i*REGW +: REGW]
//  req_ready  out  3       one-hot grant; src i accepted when valid[i]&ready[i]
//  wb_stall   in   1       1 = accept nothing this cycle (all req_ready=0)
//  result_src out  2       select to result mux: 00 src0, 01 src1, 10 src2
//  rf_we      out  1       registered write enable to register file
//  rf_rd      out  REGW    registered write address
//  rf_wd      in/out       rf_wd out WIDTH: registered mux output (y) captured on accept
//  mux_y      in   WIDTH   result mux output y (reflects result_src this cycle)
//  grant_cnt  out  3*8     per-source saturating accept counters (debug)
// BEHAVIOUR
//  - Reset (async, immediate): rr_ptr=0; rf_we=0; rf_rd=0; rf_wd=0;
//    result_src=00; req_ready=000; grant_cnt all 0. Resumes on the first clk
//    edge after reset deasserts.
//  - Grant (combinational): if wb_stall=1 or req_valid=000 -> req_ready=000,
//    result_src=00. Otherwise scan src rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3);
//    first with valid=1 wins; req_ready=onehot(winner); result_src=winner.
//  - Exactly one or zero bits of req_ready set, every cycle.
//  - Accept edge (valid&ready for winner w): rr_ptr <= (w+1) mod 3;
//    rf_rd <= req_rd[w]; rf_wd <= mux_y; rf_we <= (req_rd[w]!=0);
//    grant_cnt[w] <= min(grant_cnt[w]+1, 255).
//  - No accept: rf_we <= 0; rf_rd, rf_wd, rr_ptr hold.
//  - Latency: request accepted in cycle N -> rf_we/rf_rd/rf_wd valid in N+1;
//    one write per cycle max; back-to-back accepts give back-to-back writes.
//  - rd==0 write: accepted (ready asserted, pointer advances, counter
//    increments) but rf_we stays 0 for that slot.
//  - Requesters hold valid and rd stable until accepted; a source that
//    drops valid before acceptance simply loses the slot (no state kept).
//  - wb_stall does not cancel the slot already in the writeback register.
//  - Fairness: a continuously valid source waits at most 2 accepts.
//  - grant_cnt saturates at 255, never wraps.
//  - Reset mid-operation: in-flight writeback slot discarded (rf_we=0).
// TESTING
//  1 Reset: assert reset mid-cycle with valid=111 -> all outputs 0
//    immediately; first post-reset grant goes to src0.
//  2 Single source: valid=010, rd=5, mux_y=0xDEADBEEF -> ready=010,
//    result_src=01; next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF.
//  3 Rotation: valid=111 held 6 cycles -> grants 0,1,2,0,1,2; rf_we=1
//    every cycle from cycle 2 on.
//  4 Pointer skip: ptr=1, valid=101 -> src2 wins; next ptr=0; valid=101
//    again -> src0 wins.
//  5 rd=0 and stall: src0 rd=0 -> ready=001, next rf_we=0, ptr->1;
//    wb_stall=1 with valid=111 -> ready=000, rf_we=0 next cycle, ptr held.
//  6 Saturation: 300 accepts of src1 -> grant_cnt[1]=255, others unchanged.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle of request, grant and writeback signals between the result producers,
// the writeback arbiter and the register file write port.
interface wb_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic [2:0]        req_valid;
    logic [3*REGW-1:0] req_rd;
    logic [2:0]        req_ready;
    logic              wb_stall;
    logic [1:0]        result_src;
    logic [WIDTH-1:0]  mux_y;
    logic              rf_we;
    logic [REGW-1:0]   rf_rd;
    logic [WIDTH-1:0]  rf_wd;
    logic [3*8-1:0]    grant_cnt;

    modport master (
        output req_valid, req_rd, wb_stall, mux_y,
        input  req_ready, result_src, rf_we, rf_rd, rf_wd, grant_cnt
    );

    modport slave (
        input  req_valid, req_rd, wb_stall, mux_y,
        output req_ready, result_src, rf_we, rf_rd, rf_wd, grant_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port: picks one of three
// result producers per cycle and captures its rd/data into a writeback stage.
module wb_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);
    localparam logic [1:0] SRC0 = 2'd0;
    localparam logic [1:0] SRC1 = 2'd1;
    localparam logic [1:0] SRC2 = 2'd2;

    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             rf_we_q, rf_we_d;
    logic [REGW-1:0]  rf_rd_q, rf_rd_d;
    logic [WIDTH-1:0] rf_wd_q, rf_wd_d;
    logic [7:0]       cnt_q [3];
    logic [7:0]       cnt_d [3];

    logic [2:0]       pick_s;
    logic             accept_s;
    logic [1:0]       win_s;
    logic [2:0]       ready_s;
    logic [REGW-1:0]  win_rd_s;

    // Returns {found, index}: first valid source scanning from ptr upward, mod 3.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] valid);
        logic [1:0] o0, o1, o2;
        logic [2:0] res;
        case (ptr)
            SRC1:    begin o0 = SRC1; o1 = SRC2; o2 = SRC0; end
            SRC2:    begin o0 = SRC2; o1 = SRC0; o2 = SRC1; end
            default: begin o0 = SRC0; o1 = SRC1; o2 = SRC2; end
        endcase
        if (valid[o0]) begin
            res = {1'b1, o0};
        end else if (valid[o1]) begin
            res = {1'b1, o1};
        end else if (valid[o2]) begin
            res = {1'b1, o2};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Combinational grant; reset and stall both force an idle, zero-select cycle.
    always_comb begin
        pick_s   = rr_pick(rr_ptr_q, bus.req_valid);
        accept_s = 1'b0;
        win_s    = SRC0;
        ready_s  = 3'b000;
        if (!reset && !bus.wb_stall && pick_s[2]) begin
            accept_s = 1'b1;
            win_s    = pick_s[1:0];
            ready_s  = 3'b001 << win_s;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Destination register of the winning source.
    always_comb begin
        case (win_s)
            SRC1:    win_rd_s = bus.req_rd[REGW   +: REGW];
            SRC2:    win_rd_s = bus.req_rd[2*REGW +: REGW];
            default: win_rd_s = bus.req_rd[0      +: REGW];
        endcase
    end

    // Next-state for pointer and writeback slot; rd==0 is accepted but never written.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rf_we_d  = 1'b0;
        rf_rd_d  = rf_rd_q;
        rf_wd_d  = rf_wd_q;
        if (accept_s) begin
            case (win_s)
                SRC0:    rr_ptr_d = SRC1;
                SRC1:    rr_ptr_d = SRC2;
                default: rr_ptr_d = SRC0;
            endcase
            rf_we_d = (win_rd_s != {REGW{1'b0}});
            rf_rd_d = win_rd_s;
            rf_wd_d = bus.mux_y;
        end else begin
            rf_we_d = 1'b0;
        end
    end

    // Per-source accept counters, saturating at 255.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (accept_s && (win_s == 2'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers; reset discards any in-flight writeback slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= SRC0;
            rf_we_q  <= 1'b0;
            rf_rd_q  <= {REGW{1'b0}};
            rf_wd_q  <= {WIDTH{1'b0}};
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rf_we_q  <= rf_we_d;
            rf_rd_q  <= rf_rd_d;
            rf_wd_q  <= rf_wd_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.result_src = win_s;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.grant_cnt  = {cnt_q[2], cnt_q[1], cnt_q[0]};
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: table of grant/writeback cases
// plus hand sequences for counter saturation and mid-cycle reset.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    wb_port_arbiter_if #(.WIDTH(32), .REGW(5)) bus ();

    wb_port_arbiter #(.WIDTH(32), .REGW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic        stall;
        logic [31:0] y;
        logic [2:0]  e_ready;
        logic [1:0]  e_src;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        logic        p_we;
        logic [4:0]  p_rd;
        logic [31:0] p_wd;

        // ptr starts at 0; each row's expected state follows from the rows before it
        vecs[0]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hA000_0000, 3'b001, 2'b00, 1'b1, 5'd1, 32'hA000_0000};
        vecs[1]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hA000_0001, 3'b010, 2'b01, 1'b1, 5'd2, 32'hA000_0001};
        vecs[2]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hA000_0002, 3'b100, 2'b10, 1'b1, 5'd3, 32'hA000_0002};
        vecs[3]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hA000_0003, 3'b001, 2'b00, 1'b1, 5'd1, 32'hA000_0003};
        vecs[4]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hA000_0004, 3'b010, 2'b01, 1'b1, 5'd2, 32'hA000_0004};
        vecs[5]  = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hA000_0005, 3'b100, 2'b10, 1'b1, 5'd3, 32'hA000_0005};
        vecs[6]  = '{3'b001, {5'd3, 5'd2, 5'd4}, 1'b0, 32'hB000_0000, 3'b001, 2'b00, 1'b1, 5'd4, 32'hB000_0000};
        vecs[7]  = '{3'b101, {5'd6, 5'd2, 5'd4}, 1'b0, 32'hB000_0001, 3'b100, 2'b10, 1'b1, 5'd6, 32'hB000_0001};
        vecs[8]  = '{3'b101, {5'd6, 5'd2, 5'd4}, 1'b0, 32'hB000_0002, 3'b001, 2'b00, 1'b1, 5'd4, 32'hB000_0002};
        vecs[9]  = '{3'b010, {5'd0, 5'd5, 5'd0}, 1'b0, 32'hDEAD_BEEF, 3'b010, 2'b01, 1'b1, 5'd5, 32'hDEAD_BEEF};
        vecs[10] = '{3'b001, {5'd0, 5'd0, 5'd0}, 1'b0, 32'hC000_0000, 3'b001, 2'b00, 1'b0, 5'd0, 32'hC000_0000};
        vecs[11] = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b1, 32'hC000_0001, 3'b000, 2'b00, 1'b0, 5'd0, 32'hC000_0000};
        vecs[12] = '{3'b111, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hC000_0002, 3'b010, 2'b01, 1'b1, 5'd2, 32'hC000_0002};
        vecs[13] = '{3'b000, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hC000_0003, 3'b000, 2'b00, 1'b0, 5'd2, 32'hC000_0002};
        vecs[14] = '{3'b011, {5'd3, 5'd2, 5'd1}, 1'b0, 32'hC000_0004, 3'b001, 2'b00, 1'b1, 5'd1, 32'hC000_0004};

        bus.req_valid = 3'b111;
        bus.req_rd    = {5'd3, 5'd2, 5'd1};
        bus.wb_stall  = 1'b0;
        bus.mux_y     = 32'h1234_5678;

        #12;
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_src",   32'(bus.result_src), 32'd0);
        chk("reset_we",    32'(bus.rf_we), 32'd0);
        chk("reset_rd",    32'(bus.rf_rd), 32'd0);
        chk("reset_wd",    bus.rf_wd, 32'd0);
        chk("reset_cnt",   32'(bus.grant_cnt), 32'd0);

        @(negedge clk);
        bus.req_valid = 3'b000;
        reset = 1'b0;
        p_we = 1'b0;
        p_rd = 5'd0;
        p_wd = 32'd0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.req_valid = vecs[i].valid;
            bus.req_rd    = vecs[i].rd;
            bus.wb_stall  = vecs[i].stall;
            bus.mux_y     = vecs[i].y;
            #1;
            chk($sformatf("v%0d_hold_we", i), 32'(bus.rf_we), 32'(p_we));
            chk($sformatf("v%0d_hold_rd", i), 32'(bus.rf_rd), 32'(p_rd));
            chk($sformatf("v%0d_hold_wd", i), bus.rf_wd, p_wd);
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_src", i),   32'(bus.result_src), 32'(vecs[i].e_src));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(bus.rf_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_rd", i), 32'(bus.rf_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_wd", i), bus.rf_wd, vecs[i].e_wd);
            p_we = vecs[i].e_we;
            p_rd = vecs[i].e_rd;
            p_wd = vecs[i].e_wd;
        end
        // src0 won rows 0,3,6,8,10,14; src1 rows 1,4,9,12; src2 rows 2,5,7
        chk("cnt_after_table", 32'(bus.grant_cnt), {8'd0, 8'd3, 8'd4, 8'd6});

        // Pointer is 1 here, so src1 alone wins every cycle
        @(negedge clk);
        bus.req_valid = 3'b010;
        bus.req_rd    = {5'd0, 5'd5, 5'd0};
        bus.wb_stall  = 1'b0;
        bus.mux_y     = 32'h5A5A_5A5A;
        repeat (300) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(bus.grant_cnt), {8'd0, 8'd3, 8'd255, 8'd6});
        chk("sat_we",  32'(bus.rf_we), 32'd1);
        chk("sat_rd",  32'(bus.rf_rd), 32'd5);

        // Mid-cycle reset with an in-flight write and all sources requesting
        bus.req_valid = 3'b111;
        bus.req_rd    = {5'd3, 5'd2, 5'd1};
        bus.mux_y     = 32'h0BAD_F00D;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_we",    32'(bus.rf_we), 32'd0);
        chk("midrst_rd",    32'(bus.rf_rd), 32'd0);
        chk("midrst_wd",    bus.rf_wd, 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_src",   32'(bus.result_src), 32'd0);
        chk("midrst_cnt",   32'(bus.grant_cnt), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst_ready", 32'(bus.req_ready), 32'd1);
        chk("postrst_src",   32'(bus.result_src), 32'd0);
        @(posedge clk);
        #1;
        chk("postrst_we",  32'(bus.rf_we), 32'd1);
        chk("postrst_rd",  32'(bus.rf_rd), 32'd1);
        chk("postrst_wd",  bus.rf_wd, 32'h0BAD_F00D);
        chk("postrst_cnt", 32'(bus.grant_cnt), 32'd1);
        #1;
        chk("postrst_next_ready", 32'(bus.req_ready), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
